dmem_port_arbiter: RTL and testbench

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

---
 rtl/dmem_port_arbiter_pkg.sv | 23 ++
 rtl/starve_counter.sv | 34 +++
 rtl/dmem_port_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: read-owner encoding,
// default host starvation limit and a counter-width helper.
package dmem_port_arbiter_pkg;

  // Which requester a read granted last cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  // Cycles a host request may be refused before it is forced through.
  localparam int unsigned MAX_WAIT_DEFAULT = 4;

  // Bits needed to count 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating up-counter with synchronous clear, used to track how long the
// host has been refused the memory port.
//   clk   : clock
//   arst  : asynchronous active-high reset, forces cnt to 0
//   clr   : clear to 0 (wins over inc)
//   inc   : increment, saturating at MAX
//   cnt   : current count, range 0..MAX
module starve_counter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = MAX_WAIT_DEFAULT,
  parameter int unsigned W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_CNT = W'(MAX);

  // Count register: clear dominates, increment stops at MAX.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX_CNT)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates a single-port data SRAM between the CPU MEM stage and a host.
// The CPU wins by default; the host wins when the CPU is idle or after it has
// been refused MAX_WAIT cycles. Read data returns one cycle after the grant
// and is steered to whichever requester owned that read.
//   clk, arst               : clock, asynchronous active-high reset
//   enable                  : CPU execution enable (gates cpu_req)
//   cpu_req/wen/addr/wdata  : CPU access request
//   cpu_stall               : CPU refused this cycle
//   cpu_rvalid/rdata        : CPU read return
//   ext_req/wen/addr/wdata  : host access request
//   ext_gnt                 : host accepted this cycle
//   ext_rvalid/rdata        : host read return
//   mem_addr/wen/ren/wdata  : SRAM command, driven from the granted requester
//   mem_rdata               : SRAM read data, valid one cycle after mem_ren
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,
  input  logic              cpu_req,
  input  logic              cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_wen,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = cnt_width(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic             cpu_eff;
  logic             cpu_gnt;
  logic             ext_win;
  logic             wait_clr;
  logic             wait_inc;
  logic [CNT_W-1:0] wait_cnt;

  owner_e            owner_q;
  owner_e            owner_d;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ext_rdata_q;

  // Host starvation counter.
  starve_counter #(
    .MAX (MAX_WAIT),
    .W   (CNT_W)
  ) u_starve_counter (
    .clk  (clk),
    .arst (arst),
    .clr  (wait_clr),
    .inc  (wait_inc),
    .cnt  (wait_cnt)
  );

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    cpu_eff  = cpu_req & enable;
    ext_win  = ext_req & ((wait_cnt == WAIT_LIMIT) | ~cpu_eff);
    ext_gnt  = ext_win & ~arst;
    cpu_gnt  = cpu_eff & ~ext_win & ~arst;
    cpu_stall = cpu_eff & ~cpu_gnt;
    wait_clr = ext_gnt | ~ext_req;
    wait_inc = ext_req & ~ext_gnt;
  end

  // SRAM command mux; all-zero when idle so the bus is quiet.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_wen;
      mem_ren   = ~cpu_wen;
    end else if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_wen   = ext_wen;
      mem_ren   = ~ext_wen;
    end
  end

  // Owner of the read issued this cycle; writes leave no owner.
  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_wen) begin
      owner_d = OWN_CPU;
    end else if (ext_gnt && !ext_wen) begin
      owner_d = OWN_EXT;
    end
  end

  // Read-owner tracking and per-port hold of the last returned word.
  // Reset clears the owner, which discards any return still in flight.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      owner_q     <= OWN_NONE;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      if (owner_q == OWN_CPU) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (owner_q == OWN_EXT) begin
        ext_rdata_q <= mem_rdata;
      end
    end
  end

  // Return path: the owner sees live SRAM data, the other port holds.
  always_comb begin
    cpu_rvalid = (owner_q == OWN_CPU);
    ext_rvalid = (owner_q == OWN_EXT);
    cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    ext_rdata  = ext_rvalid ? mem_rdata : ext_rdata_q;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: default instance (MAX_WAIT=4) plus a
// MAX_WAIT=0 instance sharing the same stimulus.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        arst;
  logic        enable;
  logic        cpu_req;
  logic        cpu_wen;
  logic [63:0] cpu_addr;
  logic [63:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [63:0] cpu_rdata;
  logic        ext_req;
  logic        ext_wen;
  logic [63:0] ext_addr;
  logic [63:0] ext_wdata;
  logic        ext_gnt;
  logic        ext_rvalid;
  logic [63:0] ext_rdata;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic        mem_ren;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  logic        z_cpu_stall;
  logic        z_cpu_rvalid;
  logic [63:0] z_cpu_rdata;
  logic        z_ext_gnt;
  logic        z_ext_rvalid;
  logic [63:0] z_ext_rdata;
  logic [63:0] z_mem_addr;
  logic        z_mem_wen;
  logic        z_mem_ren;
  logic [63:0] z_mem_wdata;

  int n_vec;
  int n_err;

  dmem_port_arbiter dut (
    .clk        (clk),
    .arst       (arst),
    .enable     (enable),
    .cpu_req    (cpu_req),
    .cpu_wen    (cpu_wen),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ext_req    (ext_req),
    .ext_wen    (ext_wen),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_ren    (mem_ren),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  dmem_port_arbiter #(.MAX_WAIT(0)) dut_mw0 (
    .clk        (clk),
    .arst       (arst),
    .enable     (enable),
    .cpu_req    (cpu_req),
    .cpu_wen    (cpu_wen),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (z_cpu_stall),
    .cpu_rvalid (z_cpu_rvalid),
    .cpu_rdata  (z_cpu_rdata),
    .ext_req    (ext_req),
    .ext_wen    (ext_wen),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (z_ext_gnt),
    .ext_rvalid (z_ext_rvalid),
    .ext_rdata  (z_ext_rdata),
    .mem_addr   (z_mem_addr),
    .mem_wen    (z_mem_wen),
    .mem_ren    (z_mem_ren),
    .mem_wdata  (z_mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_eg;
    logic exp_erv;
    n_vec     = 0;
    n_err     = 0;
    arst      = 1'b1;
    enable    = 1'b1;
    cpu_req   = 1'b1;
    cpu_wen   = 1'b0;
    cpu_addr  = 64'h40;
    cpu_wdata = 64'h0;
    ext_req   = 1'b1;
    ext_wen   = 1'b0;
    ext_addr  = 64'h80;
    ext_wdata = 64'h0;
    mem_rdata = 64'h0;

    // Reset held with both requesters active.
    repeat (3) tick();
    check("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    check("rst_ext_rvalid", 64'(ext_rvalid), 64'd0);
    check("rst_wait_cnt",   64'(dut.wait_cnt), 64'd0);
    check("rst_ext_gnt",    64'(ext_gnt), 64'd0);
    check("rst_mem_ren",    64'(mem_ren), 64'd0);
    check("rst_mem_addr",   mem_addr, 64'd0);
    check("rst_cpu_rdata",  cpu_rdata, 64'd0);
    check("rst_ext_rdata",  ext_rdata, 64'd0);

    // Release: CPU wins first.
    arst = 1'b0;
    #1;
    check("rel_cpu_stall", 64'(cpu_stall), 64'd0);
    check("rel_ext_gnt",   64'(ext_gnt), 64'd0);
    check("rel_mem_ren",   64'(mem_ren), 64'd1);
    check("rel_mem_addr",  mem_addr, 64'h40);
    tick();
    cpu_req   = 1'b0;
    ext_req   = 1'b0;
    mem_rdata = 64'h77;
    #1;
    check("rel_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check("rel_cpu_rdata",  cpu_rdata, 64'h77);
    tick();
    mem_rdata = 64'hDEAD;
    #1;
    check("hold_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
    check("hold_cpu_rdata",  cpu_rdata, 64'h77);
    check("idle_wait_cnt",   64'(dut.wait_cnt), 64'd0);
    check("idle_mem_wdata",  mem_wdata, 64'd0);

    // CPU read alone.
    cpu_req  = 1'b1;
    cpu_wen  = 1'b0;
    cpu_addr = 64'h10;
    #1;
    check("crd_stall",    64'(cpu_stall), 64'd0);
    check("crd_mem_ren",  64'(mem_ren), 64'd1);
    check("crd_mem_wen",  64'(mem_wen), 64'd0);
    check("crd_mem_addr", mem_addr, 64'h10);
    tick();
    cpu_req   = 1'b0;
    mem_rdata = 64'hA5;
    #1;
    check("crd_rvalid",     64'(cpu_rvalid), 64'd1);
    check("crd_rdata",      cpu_rdata, 64'hA5);
    check("crd_ext_rvalid", 64'(ext_rvalid), 64'd0);
    tick();
    mem_rdata = 64'h0;
    #1;
    check("crd_rvalid_once", 64'(cpu_rvalid), 64'd0);

    // Contention: host forced through every 5th cycle.
    cpu_req  = 1'b1;
    cpu_wen  = 1'b0;
    cpu_addr = 64'h100;
    ext_req  = 1'b1;
    ext_wen  = 1'b0;
    ext_addr = 64'h200;
    for (int k = 1; k <= 10; k++) begin
      mem_rdata = 64'h1000 + 64'(k);
      #1;
      exp_eg = ((k % 5) == 0);
      check("ctn_ext_gnt",  64'(ext_gnt), 64'(exp_eg));
      check("ctn_stall",    64'(cpu_stall), 64'(exp_eg));
      check("ctn_mem_addr", mem_addr, exp_eg ? 64'h200 : 64'h100);
      check("mw0_ext_gnt",  64'(z_ext_gnt), 64'd1);
      check("mw0_stall",    64'(z_cpu_stall), 64'd1);
      if (k > 1) begin
        exp_erv = ((k % 5) == 1);
        check("ctn_ext_rvalid", 64'(ext_rvalid), 64'(exp_erv));
        check("ctn_cpu_rvalid", 64'(cpu_rvalid), 64'(!exp_erv));
        if (exp_erv) check("ctn_ext_rdata", ext_rdata, 64'h1000 + 64'(k));
        else         check("ctn_cpu_rdata", cpu_rdata, 64'h1000 + 64'(k));
      end
      tick();
    end
    cpu_req = 1'b0;
    ext_req = 1'b0;
    tick();
    tick();

    // Host write while the CPU is disabled.
    enable    = 1'b0;
    cpu_req   = 1'b1;
    ext_req   = 1'b1;
    ext_wen   = 1'b1;
    ext_addr  = 64'h20;
    ext_wdata = 64'h1234;
    #1;
    check("hwr_ext_gnt",   64'(ext_gnt), 64'd1);
    check("hwr_mem_wen",   64'(mem_wen), 64'd1);
    check("hwr_mem_ren",   64'(mem_ren), 64'd0);
    check("hwr_mem_wdata", mem_wdata, 64'h1234);
    check("hwr_mem_addr",  mem_addr, 64'h20);
    check("hwr_stall",     64'(cpu_stall), 64'd0);
    tick();
    ext_req = 1'b0;
    ext_wen = 1'b0;
    #1;
    check("hwr_no_rvalid",  64'(ext_rvalid), 64'd0);
    check("dis_no_grant",   64'(mem_ren), 64'd0);
    check("dis_mem_addr",   mem_addr, 64'd0);

    // Enable falls after a CPU read is granted.
    enable   = 1'b1;
    cpu_addr = 64'h30;
    #1;
    check("enf_mem_ren", 64'(mem_ren), 64'd1);
    tick();
    enable    = 1'b0;
    mem_rdata = 64'hBEEF;
    #1;
    check("enf_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check("enf_cpu_rdata",  cpu_rdata, 64'hBEEF);
    check("enf_no_grant",   64'(mem_ren), 64'd0);
    tick();
    enable  = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("enf_rvalid_once", 64'(cpu_rvalid), 64'd0);

    // Interleaved CPU then host reads.
    cpu_req  = 1'b1;
    cpu_addr = 64'h50;
    #1;
    check("ilv_cpu_addr", mem_addr, 64'h50);
    tick();
    cpu_req   = 1'b0;
    ext_req   = 1'b1;
    ext_addr  = 64'h60;
    mem_rdata = 64'h1111;
    #1;
    check("ilv_cpu_rvalid", 64'(cpu_rvalid), 64'd1);
    check("ilv_cpu_rdata",  cpu_rdata, 64'h1111);
    check("ilv_ext_gnt",    64'(ext_gnt), 64'd1);
    check("ilv_ext_addr",   mem_addr, 64'h60);
    tick();
    ext_req   = 1'b0;
    mem_rdata = 64'h2222;
    #1;
    check("ilv_ext_rvalid", 64'(ext_rvalid), 64'd1);
    check("ilv_ext_rdata",  ext_rdata, 64'h2222);
    check("ilv_cpu_quiet",  64'(cpu_rvalid), 64'd0);
    check("ilv_cpu_hold",   cpu_rdata, 64'h1111);
    tick();
    mem_rdata = 64'h3333;
    #1;
    check("ilv_ext_once",   64'(ext_rvalid), 64'd0);
    check("ilv_ext_hold",   ext_rdata, 64'h2222);

    // Reset between a host read grant and its return.
    ext_req  = 1'b1;
    ext_addr = 64'h70;
    #1;
    check("rmr_ext_gnt", 64'(ext_gnt), 64'd1);
    tick();
    ext_req   = 1'b0;
    arst      = 1'b1;
    mem_rdata = 64'h9999;
    #1;
    check("rmr_ext_rvalid", 64'(ext_rvalid), 64'd0);
    check("rmr_ext_rdata",  ext_rdata, 64'd0);
    tick();
    arst = 1'b0;
    #1;
    check("rmr_after_rel", 64'(ext_rvalid), 64'd0);
    tick();
    check("rmr_late_ext", 64'(ext_rvalid), 64'd0);
    check("rmr_late_cpu", 64'(cpu_rvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
